// File: rtl/motor_pkg.sv
// Shared motor definitions: direction encodings (also used by Motor), sequencer states, duty width.
package motor_pkg;
  localparam int SPEED_W = 10;

  localparam logic [1:0] BACKWORD = 2'b00;
  localparam logic [1:0] LEFT     = 2'b01;
  localparam logic [1:0] RIGHT    = 2'b10;
  localparam logic [1:0] FORWARD  = 2'b11;

  typedef enum logic [1:0] {
    TRACK = 2'd0,
    BRAKE = 2'd1,
    DEAD  = 2'd2
  } state_e;
endpackage

// File: rtl/ramp_tick.sv
// Free-running ramp timebase: one-cycle tick every TICK_CYCLES clocks; only reset restarts it.
module ramp_tick #(
  parameter int TICK_CYCLES = 100_000
) (
  input  logic c100MHz,
  input  logic rst,
  output logic tick
);
  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge c100MHz or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/drive_sequencer.sv
// Wheel drive sequencer: ramps duty toward the commanded target on a slow tick, brakes and
// waits out a dead time before any direction reversal, and drops to zero on emergency stop.
module drive_sequencer
  import motor_pkg::*;
#(
  parameter int TICK_CYCLES = 100_000,
  parameter int STEP        = 16,
  parameter int DEAD_TICKS  = 50
) (
  input  logic                c100MHz,
  input  logic                rst,
  input  logic                estop,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_dir,
  input  logic [SPEED_W-1:0]  cmd_speed,
  output logic [1:0]          dir,
  output logic [SPEED_W-1:0]  speed,
  output logic                busy
);
  localparam int DW = $clog2(DEAD_TICKS + 1);
  localparam logic [DW-1:0]      DEAD_LAST = DW'(DEAD_TICKS);
  localparam logic [SPEED_W:0]   STEP_W    = (SPEED_W + 1)'(STEP);

  state_e               state_q, state_d;
  logic [1:0]           dir_q, dir_d, tgt_dir_q, tgt_dir_d;
  logic [SPEED_W-1:0]   speed_q, speed_d, tgt_speed_q, tgt_speed_d;
  logic [DW-1:0]        dead_q, dead_d, dead_inc;
  logic                 tick;

  ramp_tick #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .c100MHz (c100MHz),
    .rst     (rst),
    .tick    (tick)
  );

  // One extra bit of headroom so the step never wraps; results saturate to the target or zero.
  logic [SPEED_W:0]     sp_ext, tgt_ext, up_ext, dn_ext;
  logic [SPEED_W-1:0]   ramp_up, ramp_dn, ramp_spd, brake_spd;

  assign sp_ext    = {1'b0, speed_q};
  assign tgt_ext   = {1'b0, tgt_speed_q};
  assign up_ext    = sp_ext + STEP_W;
  assign dn_ext    = (sp_ext >= STEP_W) ? (sp_ext - STEP_W) : '0;
  assign ramp_up   = (up_ext > tgt_ext) ? tgt_speed_q : up_ext[SPEED_W-1:0];
  assign ramp_dn   = (dn_ext < tgt_ext) ? tgt_speed_q : dn_ext[SPEED_W-1:0];
  assign ramp_spd  = (speed_q < tgt_speed_q) ? ramp_up : ramp_dn;
  assign brake_spd = dn_ext[SPEED_W-1:0];
  assign dead_inc  = dead_q + DW'(1);

  assign cmd_ready = !estop && (state_q != DEAD);
  assign busy      = (state_q != TRACK) || (speed_q != tgt_speed_q);
  assign dir       = dir_q;
  assign speed     = speed_q;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    speed_d     = speed_q;
    tgt_dir_d   = tgt_dir_q;
    tgt_speed_d = tgt_speed_q;
    dead_d      = dead_q;
    if (estop) begin
      // Retarget to the current direction so nothing is left pending after release.
      state_d     = TRACK;
      speed_d     = '0;
      tgt_speed_d = '0;
      tgt_dir_d   = dir_q;
      dead_d      = '0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        tgt_dir_d   = cmd_dir;
        tgt_speed_d = cmd_speed;
      end
      // Decisions use the registered target, so a same-cycle command takes effect next tick.
      case (state_q)
        TRACK: begin
          if (dir_q == tgt_dir_q) begin
            if (tick) speed_d = ramp_spd;
          end else if (speed_q == '0) begin
            dir_d = tgt_dir_q;
          end else begin
            state_d = BRAKE;
          end
        end
        BRAKE: begin
          if (dir_q == tgt_dir_q) begin
            state_d = TRACK;
          end else if (tick) begin
            speed_d = brake_spd;
            if (brake_spd == '0) begin
              state_d = DEAD;
              dead_d  = '0;
            end
          end
        end
        DEAD: begin
          speed_d = '0;
          if (tick) begin
            if (dead_inc == DEAD_LAST) begin
              dir_d   = tgt_dir_q;
              state_d = TRACK;
              dead_d  = '0;
            end else begin
              dead_d = dead_inc;
            end
          end
        end
        default: state_d = TRACK;
      endcase
    end
  end

  always_ff @(posedge c100MHz or posedge rst) begin
    if (rst) begin
      state_q     <= TRACK;
      dir_q       <= FORWARD;
      speed_q     <= '0;
      tgt_dir_q   <= FORWARD;
      tgt_speed_q <= '0;
      dead_q      <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      speed_q     <= speed_d;
      tgt_dir_q   <= tgt_dir_d;
      tgt_speed_q <= tgt_speed_d;
      dead_q      <= dead_d;
    end
  end
endmodule
